// File: rtl/comb_float32_to_fixed_point_pkg.sv
// Shared float32 field definitions for the float-to-fixed converter.
package comb_float32_to_fixed_point_pkg;

    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'd255;

    // IEEE-754 single-precision fields, MSB first.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float32_t;

    // Zero exponent covers both signed zeros and denormals.
    function automatic logic is_zero_exp(input float32_t f);
        return f.exp == '0;
    endfunction

endpackage

// File: rtl/comb_float32_to_fixed_point_core.sv
// Combinational float32 -> signed fixed-point conversion with optional
// round-half-away-from-zero and saturate-or-wrap overflow handling.
module float32_to_fixed_core
    import comb_float32_to_fixed_point_pkg::*;
#(
    parameter int WOI   = 10,
    parameter int WOF   = 10,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [31:0]        in,
    output logic [WOI+WOF-1:0] out,
    output logic               upflow,
    output logic               downflow
);

    localparam int W  = WOI + WOF;
    // Wide enough for the 24-bit significand shifted left by up to W-1,
    // plus the rounding carry on the right-shift path.
    localparam int MW = W + 25;

    localparam logic [MW-1:0] ONE     = MW'(1);
    localparam logic [MW-1:0] NEG_LIM = ONE << (W - 1);
    localparam logic [MW-1:0] POS_LIM = NEG_LIM - ONE;
    localparam logic [W-1:0]  OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  OUT_MIN = {1'b1, {(W-1){1'b0}}};

    float32_t        f;
    logic [MANT_W:0] sig;
    int              shift;
    logic [MW-1:0]   half;
    logic [MW-1:0]   mag;
    logic [MW-1:0]   neg_mag;
    logic            too_big;
    logic            ovf;
    logic [W-1:0]    wrapped;

    // Scale the significand to fixed-point units and apply rounding.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        f       = float32_t'(in);
        sig     = {1'b1, f.mant};
        shift   = int'(f.exp) - (EXP_BIAS + MANT_W) + WOF;
        half    = '0;
        mag     = '0;
        too_big = 1'b0;
        if (shift >= W) begin
            // Leading one lands at or above bit W: overflow, wrapped bits all zero.
            too_big = 1'b1;
        end else if (shift >= 0) begin
            mag = MW'(sig) << shift;
        end else begin
            // Keep one extra bit below the LSB so rounding is a single add.
            half = MW'(sig) >> (-shift - 1);
            mag  = (ROUND != 0) ? ((half + ONE) >> 1) : (half >> 1);
        end
        neg_mag = -mag;
        wrapped = f.sign ? neg_mag[W-1:0] : mag[W-1:0];
        ovf     = too_big || (f.sign ? (mag > NEG_LIM) : (mag > POS_LIM));
    end

    // Select the final value and flags by input class.
    always_comb begin
        out      = '0;
        upflow   = 1'b0;
        downflow = 1'b0;
        if (f.exp == EXP_SPECIAL) begin
            upflow = 1'b1;
            out    = f.sign ? OUT_MIN : OUT_MAX;
        end else if (is_zero_exp(f)) begin
            downflow = (f.mant != '0);
        end else if (ovf) begin
            upflow = 1'b1;
            if (ROOF != 0) begin
                out = f.sign ? OUT_MIN : OUT_MAX;
            end else begin
                out = wrapped;
            end
        end else begin
            out      = wrapped;
            downflow = (mag == '0);
        end
    end

endmodule

// File: rtl/comb_float32_to_fixed_point.sv
// Top level: combinational float32 -> fixed conversion, registered once.
module comb_float32_to_fixed_point #(
    parameter int WOI   = 10,
    parameter int WOF   = 10,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        in,
    output logic [WOI+WOF-1:0] out,
    output logic               upflow,
    output logic               downflow
);

    logic [WOI+WOF-1:0] out_c;
    logic               upflow_c;
    logic               downflow_c;

    float32_to_fixed_core #(
        .WOI  (WOI),
        .WOF  (WOF),
        .ROOF (ROOF),
        .ROUND(ROUND)
    ) u_core (
        .in      (in),
        .out     (out_c),
        .upflow  (upflow_c),
        .downflow(downflow_c)
    );

    // Output register; asynchronous reset clears result and flags.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make register updates independent of evaluation order.
        if (rst) begin
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
        end else begin
            out      <= out_c;
            upflow   <= upflow_c;
            downflow <= downflow_c;
        end
    end

endmodule

// File: tb/tb_comb_float32_to_fixed_point.sv
// Self-checking bench: literal directed vectors plus a real-arithmetic model
// compared against three parameter variants every cycle.
module tb_comb_float32_to_fixed_point;

    localparam int WOI = 10;
    localparam int WOF = 10;
    localparam int W   = WOI + WOF;
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] o;
        logic         up;
        logic         dn;
    } res_t;

    typedef struct packed {
        logic [31:0]  x;
        logic [W-1:0] o;
        logic         up;
        logic         dn;
        logic [1:0]   alt;   // 0 none, 1 wrap instance, 2 truncating instance
        logic [W-1:0] ao;
        logic         aup;
        logic         adn;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  din = '0;

    logic [W-1:0] out_m, out_w, out_t;
    logic         up_m, up_w, up_t;
    logic         dn_m, dn_w, dn_t;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    comb_float32_to_fixed_point #(.WOI(WOI), .WOF(WOF), .ROOF(1), .ROUND(1)) dut_main (
        .clk(clk), .rst(rst), .in(din), .out(out_m), .upflow(up_m), .downflow(dn_m)
    );
    comb_float32_to_fixed_point #(.WOI(WOI), .WOF(WOF), .ROOF(0), .ROUND(1)) dut_wrap (
        .clk(clk), .rst(rst), .in(din), .out(out_w), .upflow(up_w), .downflow(dn_w)
    );
    comb_float32_to_fixed_point #(.WOI(WOI), .WOF(WOF), .ROOF(1), .ROUND(0)) dut_trunc (
        .clk(clk), .rst(rst), .in(din), .out(out_t), .upflow(up_t), .downflow(dn_t)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    endtask

    // Reference: evaluate the float as a real number, scale, round, then classify.
    function automatic res_t model(input logic [31:0] x, input int roof, input int rnd);
        res_t   r;
        logic   s;
        int     e;
        real    v, q, lim, qm;
        longint lo, val;
        r = '0;
        s = x[31];
        e = int'(x[30:23]);
        if (e == 255) begin
            r.up = 1'b1;
            r.o  = s ? MINV : MAXV;
            return r;
        end
        if (e == 0) begin
            r.dn = (x[22:0] != 23'd0);
            return r;
        end
        v   = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127)) * (2.0 ** WOF);
        q   = (rnd != 0) ? $floor(v + 0.5) : $floor(v);
        lim = s ? (2.0 ** (W - 1)) : (2.0 ** (W - 1)) - 1.0;
        if (q > lim) begin
            r.up = 1'b1;
            if (roof != 0) begin
                r.o = s ? MINV : MAXV;
            end else begin
                qm  = q - $floor(q / (2.0 ** W)) * (2.0 ** W);
                lo  = longint'(qm);
                val = s ? -lo : lo;
                r.o = val[W-1:0];
            end
        end else begin
            lo   = longint'(q);
            val  = s ? -lo : lo;
            r.o  = val[W-1:0];
            r.dn = (q == 0.0);
        end
        return r;
    endfunction

    // Input captured at each rising edge, and whether reset was released there.
    logic [31:0] samp_in = '0;
    logic        samp_valid = 1'b0;
    always @(posedge clk) begin
        samp_in    <= din;
        samp_valid <= !rst;
    end

    // Compare all three instances against the model on every falling edge.
    res_t em, ew, et;
    always @(negedge clk) begin
        if (rst || !samp_valid) begin
            em = '0; ew = '0; et = '0;
        end else begin
            em = model(samp_in, 1, 1);
            ew = model(samp_in, 0, 1);
            et = model(samp_in, 1, 0);
        end
        check("model_main", {up_m, dn_m, out_m}, {em.up, em.dn, em.o});
        check("model_wrap", {up_w, dn_w, out_w}, {ew.up, ew.dn, ew.o});
        check("model_trunc", {up_t, dn_t, out_t}, {et.up, et.dn, et.o});
        check("flags_exclusive", up_m & dn_m, 1'b0);
    end

    vec_t vecs [19];

    initial begin
        vecs = '{
            '{32'hC36F0D77, 20'hC43CA, 1'b0, 1'b0, 2'd2, 20'hC43CB, 1'b0, 1'b0},
            '{32'h407E7564, 20'h00FE7, 1'b0, 1'b0, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'h44696E31, 20'h7FFFF, 1'b1, 1'b0, 2'd1, 20'hE96E3, 1'b1, 1'b0},
            '{32'hC427F97F, 20'h80000, 1'b1, 1'b0, 2'd1, 20'h58068, 1'b1, 1'b0},
            '{32'h00000000, 20'h00000, 1'b0, 1'b0, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'h80000000, 20'h00000, 1'b0, 1'b0, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'h7F800000, 20'h7FFFF, 1'b1, 1'b0, 2'd1, 20'h7FFFF, 1'b1, 1'b0},
            '{32'h7FC00000, 20'h7FFFF, 1'b1, 1'b0, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'hFF800000, 20'h80000, 1'b1, 1'b0, 2'd1, 20'h80000, 1'b1, 1'b0},
            '{32'h38D1B717, 20'h00000, 1'b0, 1'b1, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'h3A000000, 20'h00001, 1'b0, 1'b0, 2'd2, 20'h00000, 1'b0, 1'b1},
            '{32'hBA000000, 20'hFFFFF, 1'b0, 1'b0, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'hC4000000, 20'h80000, 1'b0, 1'b0, 2'd1, 20'h80000, 1'b0, 1'b0},
            '{32'h44000000, 20'h7FFFF, 1'b1, 1'b0, 2'd1, 20'h80000, 1'b1, 1'b0},
            '{32'h00000001, 20'h00000, 1'b0, 1'b1, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'h4F000000, 20'h7FFFF, 1'b1, 1'b0, 2'd1, 20'h00000, 1'b1, 1'b0},
            '{32'h3F800000, 20'h00400, 1'b0, 1'b0, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'hBF400000, 20'hFFD00, 1'b0, 1'b0, 2'd0, 20'h00000, 1'b0, 1'b0},
            '{32'h407E7564, 20'h00FE7, 1'b0, 1'b0, 2'd2, 20'h00FE7, 1'b0, 1'b0}
        };

        // Reset state, with a nonzero input present.
        din = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {up_m, dn_m, out_m}, '0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Directed vectors, one per cycle, each checked one edge later.
        foreach (vecs[i]) begin
            @(negedge clk);
            #1 din = vecs[i].x;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out", i), out_m, vecs[i].o);
            check($sformatf("vec%0d_flags", i), {up_m, dn_m}, {vecs[i].up, vecs[i].dn});
            if (vecs[i].alt == 2'd1)
                check($sformatf("vec%0d_wrap", i), {up_w, dn_w, out_w},
                      {vecs[i].aup, vecs[i].adn, vecs[i].ao});
            else if (vecs[i].alt == 2'd2)
                check($sformatf("vec%0d_trunc", i), {up_t, dn_t, out_t},
                      {vecs[i].aup, vecs[i].adn, vecs[i].ao});
        end

        // Back-to-back stream across interesting exponent ranges.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ex;
            case ($urandom_range(3, 0))
                0:       ex = 8'($urandom_range(150, 110));
                1:       ex = ($urandom_range(1, 0) != 0) ? 8'd255 : 8'd0;
                2:       ex = 8'($urandom_range(255, 0));
                default: ex = 8'($urandom_range(140, 126));
            endcase
            @(negedge clk);
            #1 din = {1'($urandom_range(1, 0)), ex, 23'($urandom)};
            if (i == 150) begin
                // Make the pending result nonzero, then reset between edges.
                din = 32'h3F800000;
                @(posedge clk);
                #1 check("pre_reset_out", out_m, 20'h00400);
                #1 rst = 1'b1;
                #1 check("async_reset", {up_m, dn_m, out_m, up_w, dn_w, out_w}, '0);
                @(negedge clk);
                #1 rst = 1'b0;
                din = 32'hBF400000;
                @(posedge clk);
                #1 check("post_reset_first", out_m, 20'hFFD00);
            end
        end

        @(negedge clk);
        #1 $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comb_float32_to_fixed_point.md
# comb_float32_to_fixed_point

Converts an IEEE-754 single-precision value to a signed two's-complement fixed-point number with parameterizable integer and fractional widths. The block offers optional saturation and round-to-nearest, and flags overflow and underflow. It sits between floating-point producers (host, soft-float units) and fixed-point datapaths. The conversion is combinational and the outputs are registered once, so a result appears one clock after its input.

## Interface
- `WOI`, default 10: output integer bits, sign included; legal range 2..32.
- `WOF`, default 10: output fractional bits; legal range 0..32.
- `ROOF`, default 1: 1 = saturate on overflow; 0 = wrap (keep the low `WOI+WOF` bits).
- `ROUND`, default 1: 1 = round to nearest, ties away from zero; 0 = truncate toward zero.
- `clk` input, 1 bit: the single clock; all registers use its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in` input, 32 bits: float32 operand (sign[31], exp[30:23], mantissa[22:0]).
- `out` output, `WOI+WOF` bits: signed fixed-point result; LSB weight is 2^-WOF.
- `upflow` output, 1 bit: the result overflowed the representable range, or the input was Inf or NaN.
- `downflow` output, 1 bit: the input was nonzero, but the result quantized to zero.

## Operation
- Value range: MIN = -2^(WOI-1), MAX = 2^(WOI-1) - 2^-WOF.
- Zero input (+0 or -0): `out`=0, `upflow`=0, `downflow`=0.
- Denormal input (exp=0, mantissa≠0): `out`=0, `downflow`=1.
- Inf or NaN input (exp=255): `upflow`=1.
  - Saturate toward the sign bit: positive gives MAX, negative gives MIN.
  - This holds regardless of `ROOF`.
- Normal input: form the magnitude 1.mantissa × 2^(exp-127).
  - Scale by 2^WOF with an exact barrel shift.
  - If `ROUND`=1, add half an LSB to the magnitude, then truncate. Otherwise truncate only.
  - Negate if the sign bit is set. The net effect is rounding half away from zero.
- Overflow check, done after rounding:
  - Positive magnitude > MAX·2^WOF, or negative magnitude > 2^(WOI-1+WOF), sets `upflow`=1.
  - Exactly -2^(WOI-1) is representable and does not overflow.
  - If `ROOF`=1, `out` saturates to MAX or MIN.
  - If `ROOF`=0, `out` takes the low `WOI+WOF` bits of the exact two's-complement result.
  - When the exponent is large enough that every in-range bit is shifted out, the wrapped result is 0.
- Underflow: a nonzero normal input whose rounded result is 0 gives `downflow`=1.
- `upflow` and `downflow` are never both 1.

## Timing
- Fully pipelined: accepts a new `in` every cycle, with no handshake.
- Latency is 1 cycle: `out`, `upflow` and `downflow` reflect the `in` sampled at the previous rising edge of `clk`.
- While `rst`=1, and asynchronously on its assertion, `out`=0, `upflow`=0 and `downflow`=0.
- The first valid result appears one edge after `rst` deasserts.
- The combinational path from `in` to the register D input must close at the target clock without internal pipelining.

## Structure
- Shared package:
  - float32 field constants: `EXP_BIAS`=127, `MANT_W`=23, `EXP_W`=8, `EXP_SPECIAL`=255.
  - A packed struct for float32 fields.
- Sub-module `float32_to_fixed_core`: purely combinational, holding all of Operation.
- The top level instantiates the core and adds only the reset-able output register.

## Test plan
All cases use `WOI`=10, `WOF`=10, `ROOF`=1, `ROUND`=1 unless stated; check each result one cycle after applying `in`.
- **Rounding, both signs:**
  - 0xC36F0D77 (-239.052599) → `out`=-244790 (-239.052734), flags 0.
  - 0x407E7564 (3.975915) → `out`=4071 (3.975586), flags 0.
- **Saturation:**
  - 0x44696E31 (933.72) → 0x7FFFF (511.999023), `upflow`=1.
  - 0xC427F97F (-671.9) → 0x80000 (-512.0), `upflow`=1.
  - Repeat both with `ROOF`=0: `out` holds the wrapped low 20 bits, `upflow`=1.
- **Specials:**
  - 0x00000000 and 0x80000000 → 0, flags 0.
  - 0x7F800000 and 0x7FC00000 → 0x7FFFF, `upflow`=1.
  - 0xFF800000 → 0x80000, `upflow`=1.
- **Underflow and ties:**
  - 0x38D1B717 (1e-4) → 0, `downflow`=1.
  - 0x3A000000 (2^-11) → 0x00001 with `ROUND`=1; → 0 with `downflow`=1 when `ROUND`=0.
  - 0xBA000000 → 0xFFFFF with `ROUND`=1.
- **Boundary:** 0xC4000000 (-512.0) → 0x80000 with `upflow`=0; 0x44000000 (512.0) → 0x7FFFF with `upflow`=1.
- **Reset and throughput:**
  - Stream a new input every cycle: each result appears exactly 1 cycle later.
  - Assert `rst` mid-stream: all outputs go to 0 immediately, without waiting for a clock edge.
